// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types, defaults and helpers for the PS/2 host transmitter.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    // 120 us inhibit and 15 ms timeout at 50 MHz
    localparam int unsigned c_INHIBIT_CYCLES = 6000;
    localparam int unsigned c_TIMEOUT_CYCLES = 750000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx_if
// Brief    : Requester handshake for the PS/2 host transmitter.
// Revision : 1.0
// ============================================================================
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_err
    );

endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_sync
// Brief    : 2-flop synchronizer and registered falling-edge pulse for one
//            PS/2 line.
// Revision : 1.0
// ============================================================================
module ps2_line_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_pin,
    output logic      o_sync,
    output logic      o_fe
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_fe;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
            r_fe     <= 1'b0;
        end else begin
            r_meta   <= i_pin;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_fe     <= r_sync_d & ~r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fe   = r_fe;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : Host-to-device PS/2 command transmitter, open-drain line drive.
// Revision : 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = c_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  wire logic    CLOCK_50,
    input  wire logic    RESET_N,
    ps2_host_tx_if.slave tx,
    input  wire logic    PS2_CLK_IN,
    input  wire logic    PS2_DAT_IN,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);

    localparam int unsigned c_INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned c_TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [9:0]         r_shift;
    logic [3:0]         r_bit_cnt;
    logic [c_INH_W-1:0] r_inh_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               r_idle_seen;
    logic               r_clk_oe;
    logic               r_dat_oe;
    logic               r_done;
    logic               r_err;

    logic w_clk_sync;
    logic w_clk_fe;
    logic w_dat_sync;
    logic w_dat_fe_unused;
    logic w_active;
    logic w_to_hit;
    logic w_shift_step;
    logic w_lines_idle;
    logic w_clk_oe_nxt;
    logic w_dat_oe_nxt;
    logic w_done_nxt;
    logic w_err_nxt;

    ps2_line_sync u_clk_sync (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .i_pin  (PS2_CLK_IN),
        .o_sync (w_clk_sync),
        .o_fe   (w_clk_fe)
    );

    ps2_line_sync u_dat_sync (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .i_pin  (PS2_DAT_IN),
        .o_sync (w_dat_sync),
        .o_fe   (w_dat_fe_unused)
    );

    assign w_active     = (r_state == RTS) || (r_state == SHIFT) ||
                          (r_state == ACK) || (r_state == WAIT_IDLE);
    assign w_to_hit     = w_active && !w_clk_fe && (r_to_cnt == c_TO_LAST);
    // Device edges 1..9 move data bits 0..7 and then parity onto the line
    assign w_shift_step = (r_state == SHIFT) && w_clk_fe && (r_bit_cnt < 4'd9);
    assign w_lines_idle = w_clk_sync && w_dat_sync;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (tx.tx_valid) w_state_nxt = INHIBIT;
            INHIBIT:   if (r_inh_cnt == c_INH_LAST) w_state_nxt = RTS;
            RTS:       w_state_nxt = SHIFT;
            SHIFT:     if (w_clk_fe && (r_bit_cnt == 4'd9)) w_state_nxt = ACK;
            ACK:       if (w_clk_fe) w_state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (r_idle_seen && w_lines_idle) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
        if (w_to_hit) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        w_clk_oe_nxt = (w_state_nxt == INHIBIT);
        w_dat_oe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = w_to_hit;
        case (w_state_nxt)
            RTS:     w_dat_oe_nxt = 1'b1;
            SHIFT:   w_dat_oe_nxt = w_shift_step ? ~r_shift[0] : r_dat_oe;
            default: w_dat_oe_nxt = 1'b0;
        endcase
        // A timeout needs a quiet cycle, so it can never coincide with the ACK edge
        if ((r_state == ACK) && w_clk_fe) begin
            w_done_nxt = ~w_dat_sync;
            w_err_nxt  = w_dat_sync;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_inh_cnt   <= '0;
            r_to_cnt    <= '0;
            r_idle_seen <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_dat_oe    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == IDLE) && tx.tx_valid) begin
                r_shift <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
            end else if (w_shift_step) begin
                r_shift <= {1'b1, r_shift[9:1]};
            end

            if (w_state_nxt == RTS) begin
                r_bit_cnt <= '0;
            end else if (((r_state == SHIFT) || (r_state == ACK)) && w_clk_fe) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if ((r_state == INHIBIT) && (w_state_nxt == INHIBIT)) begin
                r_inh_cnt <= r_inh_cnt + 1'b1;
            end else begin
                r_inh_cnt <= '0;
            end

            if (w_active && !w_clk_fe && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            r_idle_seen <= (r_state == WAIT_IDLE) && w_lines_idle;
            r_clk_oe    <= w_clk_oe_nxt;
            r_dat_oe    <= w_dat_oe_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_dat_oe  = r_dat_oe;
    assign tx.tx_ready = (r_state == IDLE);
    assign tx.tx_done  = r_done;
    assign tx.tx_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Self-checking bench: PS/2 keyboard model plus frame reference.
// Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INH = 400;
    localparam int c_TO  = 2500;
    localparam int c_HP  = 20;

    logic CLOCK_50 = 1'b0;
    logic RESET_N;
    logic dev_clk;
    logic dev_dat;
    logic ps2_clk_oe;
    logic ps2_dat_oe;

    wire clk_line = dev_clk & ~ps2_clk_oe;
    wire dat_line = dev_dat & ~ps2_dat_oe;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;
    bit stop_flag;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_host_tx_if u_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_INH),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .tx         (u_if.slave),
        .PS2_CLK_IN (clk_line),
        .PS2_DAT_IN (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always @(negedge CLOCK_50) begin
        if (u_if.tx_done === 1'b1) n_done++;
        if (u_if.tx_err === 1'b1) n_err++;
        if ((u_if.tx_done === 1'b1) && (u_if.tx_err === 1'b1)) n_both++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line levels the keyboard sees: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_model(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic dev_frame(input bit ack, input int stop_at, output logic [10:0] bits);
        int n;
        bits = '1;
        n = 0;
        while ((ps2_clk_oe === 1'b1) && (n < c_INH + 50)) begin
            n++;
            @(negedge CLOCK_50);
        end
        check_eq("inhibit_len", n, c_INH);
        check_eq("rts_dat_oe", ps2_dat_oe, 1);
        bits[0] = dat_line;
        repeat (c_HP) @(negedge CLOCK_50);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == stop_at) begin
                repeat (8) @(negedge CLOCK_50);
                return;
            end
            repeat (c_HP) @(negedge CLOCK_50);
            dev_clk = 1'b1;
            if (k <= 10) bits[k] = dat_line;
            if ((k == 10) && ack) begin
                repeat (5) @(negedge CLOCK_50);
                dev_dat = 1'b0;
                repeat (c_HP - 5) @(negedge CLOCK_50);
            end else begin
                repeat (c_HP) @(negedge CLOCK_50);
            end
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while ((u_if.tx_ready !== 1'b1) && (n < 1000)) begin
            n++;
            @(negedge CLOCK_50);
        end
        check_eq("ready_back", u_if.tx_ready, 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ack);
        int d0;
        int e0;
        logic [10:0] bits;
        d0 = n_done;
        e0 = n_err;
        @(negedge CLOCK_50);
        u_if.tx_data  = d;
        u_if.tx_valid = 1'b1;
        @(negedge CLOCK_50);
        u_if.tx_valid = 1'b0;
        check_eq("capture_clk_oe", ps2_clk_oe, 1);
        check_eq("busy_ready", u_if.tx_ready, 0);
        dev_frame(ack, 0, bits);
        check_eq("frame", bits, frame_model(d));
        wait_ready();
        check_eq("done_cnt", n_done - d0, ack);
        check_eq("err_cnt", n_err - e0, !ack);
        check_eq("lines_idle", {ps2_clk_oe, ps2_dat_oe}, 0);
    endtask

    initial begin
        int n;
        int d0;
        int e0;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [10:0] bits;

        RESET_N       = 1'b0;
        dev_clk       = 1'b1;
        dev_dat       = 1'b1;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        check_eq("rst_ready", u_if.tx_ready, 1);
        check_eq("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check_eq("rst_pulses", {u_if.tx_done, u_if.tx_err}, 0);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        send_frame(8'hED, 1'b1);
        send_frame(8'hF4, 1'b1);
        send_frame(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b0);

        // Keyboard never clocks after the request-to-send
        d0 = n_done;
        e0 = n_err;
        @(negedge CLOCK_50);
        u_if.tx_data  = 8'($urandom);
        u_if.tx_valid = 1'b1;
        @(negedge CLOCK_50);
        u_if.tx_valid = 1'b0;
        n = 0;
        while ((ps2_clk_oe === 1'b1) && (n < c_INH + 50)) begin
            n++;
            @(negedge CLOCK_50);
        end
        n = 0;
        while ((u_if.tx_err !== 1'b1) && (n < c_TO + 100)) begin
            n++;
            @(negedge CLOCK_50);
        end
        check_eq("timeout_len", ((n >= c_TO - 1) && (n <= c_TO + 1)), 1);
        check_eq("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check_eq("timeout_ready", u_if.tx_ready, 1);
        @(negedge CLOCK_50);
        check_eq("timeout_err_once", n_err - e0, 1);
        check_eq("timeout_no_done", n_done - d0, 0);

        // Reset asserted while the keyboard holds clock low on edge 5
        @(negedge CLOCK_50);
        u_if.tx_data  = 8'h00;
        u_if.tx_valid = 1'b1;
        @(negedge CLOCK_50);
        u_if.tx_valid = 1'b0;
        dev_frame(1'b1, 5, bits);
        check_eq("pre_rst_dat_oe", ps2_dat_oe, 1);
        d0 = n_done;
        e0 = n_err;
        #2 RESET_N = 1'b0;
        #1 check_eq("async_release", {ps2_clk_oe, ps2_dat_oe}, 0);
        dev_clk = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        check_eq("post_rst_ready", u_if.tx_ready, 1);
        check_eq("post_rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check_eq("post_rst_pulses", (n_done - d0) + (n_err - e0), 0);

        // tx_valid held high with tx_data churning during the transfer
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        d0 = n_done;
        @(negedge CLOCK_50);
        u_if.tx_data  = b0;
        u_if.tx_valid = 1'b1;
        @(negedge CLOCK_50);
        check_eq("hold_capture", ps2_clk_oe, 1);
        stop_flag = 1'b0;
        fork
            begin
                dev_frame(1'b1, 0, bits);
                stop_flag = 1'b1;
            end
            begin
                while (!stop_flag) begin
                    @(negedge CLOCK_50);
                    if (!stop_flag) u_if.tx_data = 8'($urandom);
                end
            end
        join
        check_eq("hold_frame", bits, frame_model(b0));
        u_if.tx_data = b1;
        n = 0;
        while ((u_if.tx_ready !== 1'b1) && (n < 1000)) begin
            n++;
            @(negedge CLOCK_50);
        end
        check_eq("hold_ready", u_if.tx_ready, 1);
        check_eq("hold_no_early", ps2_clk_oe, 0);
        check_eq("hold_done", n_done - d0, 1);
        @(negedge CLOCK_50);
        check_eq("hold_second_start", ps2_clk_oe, 1);
        u_if.tx_valid = 1'b0;
        dev_frame(1'b1, 0, bits);
        check_eq("hold_second_frame", bits, frame_model(b1));
        wait_ready();

        check_eq("never_both", n_both, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
